fir_mac_sequencer: RTL and testbench
====================================

// Module: fir_mac_sequencer
// PURPOSE
//  Time-multiplexed FIR controller for the shared 16x16 ALU (op_sel/a/b -> registered 32-bit result).
//  Holds the coefficient bank and the sample delay line.
//  Per accepted input sample it issues NTAPS multiply ops to the ALU and accumulates the returning products.
//  Presents y[n] = sum c[k]*x[n-k] on a valid/ready output.
// PARAMETERS
//  NTAPS    16  number of taps, >=2, need not be a power of two
//  DATA_W   16  sample/coefficient width, signed
//  ALU_LAT  1   cycles from op issue to product on alu_result, >=1
//  ACC_W    40  accumulator/output width, >= 2*DATA_W + clog2(NTAPS)
// PORTS
//  clk         in   1        clock
//  rst         in   1        synchronous reset, active-high
//  in_valid    in   1        input sample valid
//  in_ready    out  1        block can accept a sample
//  in_data     in   DATA_W   signed input sample
//  out_valid   out  1        filter output valid
//  out_ready   in   1        downstream accepts output
//  out_data    out  ACC_W    signed filter output
//  coef_we     in   1        coefficient write strobe
//  coef_addr   in   clog2(NTAPS)  coefficient index k
//  coef_data   in   DATA_W   signed coefficient value
//  busy        out  1        state != IDLE
//  alu_op      out  2        ALU op_sel (OP_MUL/OP_ADD/OP_SUB)
//  alu_a       out  DATA_W   ALU operand a (sample)
//  alu_b       out  DATA_W   ALU operand b (coefficient)
//  alu_result  in   32       ALU result, valid ALU_LAT cycles after issue
// BEHAVIOUR
//  Reset:
//   - State IDLE; head=0; acc=0; tag pipe cleared.
//   - Delay line and coefficients all zero.
//   - Outputs: in_ready=1, out_valid=0, out_data=0, busy=0, alu_op=OP_MUL, alu_a=0, alu_b=0.
//  FSM IDLE -> ISSUE -> DRAIN -> OUT -> IDLE.
//  IDLE:
//   - in_ready=1.
//   - On in_valid: head<=(head==NTAPS-1)?0:head+1; dl[new head]<=in_data; acc<=0; k<=0; go ISSUE.
//  ISSUE:
//   - One op per cycle: alu_op=OP_MUL, alu_a=dl[(head-k) mod NTAPS], alu_b=coef[k].
//   - k++ each cycle; after issuing k=NTAPS-1 go DRAIN.
//   - Each issue pushes a 1 into an ALU_LAT-deep tag shift register.
//  Accumulation (any state):
//   - When the tag pipe output is 1: acc <= acc + sign_ext(alu_result).
//   - Two's-complement wrap; no saturation.
//  DRAIN:
//   - Idle operands (OP_MUL, 0, 0).
//   - When the tag pipe is empty and the last product has been added, go OUT.
//  OUT:
//   - out_valid=1; out_data=acc, held stable while out_ready=0.
//   - On out_ready: go IDLE. The same cycle is not an input accept; in_ready is 0 in OUT.
//  Latency:
//   - Sample accepted on cycle C -> out_valid first high on cycle C+NTAPS+ALU_LAT+1.
//   - Throughput: one sample per NTAPS+ALU_LAT+2 cycles at best.
//  Coefficients:
//   - coef_we honoured only in IDLE; ignored (no effect, no error) in all other states.
//   - coef_we together with an in_valid accept in IDLE: the write lands first; the new sample uses the new coefficient.
//  Idle operands: alu_op=OP_MUL, a=b=0 whenever not in ISSUE.
//  Reset mid-operation:
//   - Immediate return to reset state.
//   - In-flight ALU results are discarded (tag pipe cleared).
//   - Delay line and coefficients zeroed.
//  The ALU shares clk/rst.
// STRUCTURE
//  fir_pkg: OP_MUL=2'b00, OP_ADD=2'b01, OP_SUB=2'b10, FSM state encodings, clog2 function.
//  Sub-module fir_delay_line:
//   - NTAPS x DATA_W circular buffer with head pointer, modulo index (head-k) and synchronous clear.
//  FSM, tap counter, tag pipe and accumulator live in the top.
// TESTING (NTAPS=16, ALU_LAT=1, ACC_W=40, real alu instance)
//  1. coef[k]=k+1; inputs 1 then 17 zeros -> outputs 1,2,...,16, then 0, 0.
//  2. Sample accepted cycle C -> out_valid rises exactly C+18; in_ready=0 from C+1 until the output handshake.
//  3. All coefs=-32768, sixteen inputs of -32768 -> 16th output = 17179869184 (2^34); no overflow.
//  4. out_ready held 0 for 5 cycles in OUT -> out_data/out_valid stable; in_valid ignored.
//  5. coef_we to k=0 during ISSUE -> ignored, output unchanged. Same write in IDLE with in_valid -> new coef used.
//  6. rst asserted mid-ISSUE (k=7) -> next cycle all outputs at reset values; next impulse gives 0 (coefs cleared).

Source files
------------

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR MAC sequencer: ALU op codes, FSM states, clog2.
package fir_pkg;

    localparam logic [1:0] OP_MUL = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_DRAIN = 2'b10,
        S_OUT   = 2'b11
    } state_e;

    // Number of bits needed to index n entries (n >= 2).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

endpackage

// File: rtl/fir_delay_line.sv
// Circular sample buffer: a push advances head and writes the newest sample
// there; the read port returns the sample k steps older than head.
module fir_delay_line import fir_pkg::*; #(
    parameter int NTAPS  = 16,
    parameter int DATA_W = 16,
    localparam int AW    = clog2(NTAPS)
) (
    input  logic              clk_i,
    input  logic              clr_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [AW-1:0]     k_i,
    output logic [DATA_W-1:0] data_o
);

    logic [AW-1:0]     head_q, head_d;
    logic [AW-1:0]     idx;
    logic [DATA_W-1:0] dl_q [NTAPS];

    // Next head, wrapping explicitly so NTAPS need not be a power of two.
    always_comb begin
        head_d = (head_q == AW'(NTAPS - 1)) ? '0 : head_q + AW'(1);
    end

    // Read index (head - k) mod NTAPS; the final value is always < NTAPS,
    // so modulo-2^AW intermediate arithmetic is exact.
    always_comb begin
        if (head_q >= k_i) idx = head_q - k_i;
        else               idx = head_q + AW'(NTAPS) - k_i;
    end

    assign data_o = dl_q[idx];

    // Storage and head pointer, cleared synchronously.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            head_q <= '0;
            for (int i = 0; i < NTAPS; i++) dl_q[i] <= '0;
        end else if (push_i) begin
            head_q         <= head_d;
            dl_q[head_d]   <= data_i;
        end
    end

endmodule

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR controller: per accepted sample it issues NTAPS
// multiplies to a shared ALU, accumulates the returning products and
// presents the sum on a valid/ready output.
module fir_mac_sequencer import fir_pkg::*; #(
    parameter int NTAPS   = 16,
    parameter int DATA_W  = 16,
    parameter int ALU_LAT = 1,
    parameter int ACC_W   = 40,
    localparam int AW     = clog2(NTAPS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [ACC_W-1:0]  out_data_o,
    input  logic              coef_we_i,
    input  logic [AW-1:0]     coef_addr_i,
    input  logic [DATA_W-1:0] coef_data_i,
    output logic              busy_o,
    output logic [1:0]        alu_op_o,
    output logic [DATA_W-1:0] alu_a_o,
    output logic [DATA_W-1:0] alu_b_o,
    input  logic [31:0]       alu_result_i
);

    // Tag pipe output bit; the product for that tag is on alu_result_i now.
    localparam logic [ALU_LAT-1:0] TAG_LAST = ALU_LAT'(1) << (ALU_LAT - 1);
    localparam logic [AW-1:0]      K_LAST   = AW'(NTAPS - 1);

    state_e             state_q, state_d;
    logic [AW-1:0]      k_q, k_d;
    logic [ALU_LAT-1:0] tag_q;
    logic [ACC_W-1:0]   acc_q;
    logic [DATA_W-1:0]  coef_q [NTAPS];
    logic [DATA_W-1:0]  tap_sample;
    logic [ACC_W-1:0]   product_ext;
    logic               accept, issue, coef_wr;

    fir_delay_line #(
        .NTAPS  (NTAPS),
        .DATA_W (DATA_W)
    ) u_dl (
        .clk_i  (clk_i),
        .clr_i  (rst_i),
        .push_i (accept),
        .data_i (in_data_i),
        .k_i    (k_q),
        .data_o (tap_sample)
    );

    assign product_ext = {{(ACC_W - 32){alu_result_i[31]}}, alu_result_i};

    // Next state, tap counter and all block outputs; idle operands by default.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        out_data_o  = '0;
        busy_o      = 1'b1;
        alu_op_o    = OP_MUL;
        alu_a_o     = '0;
        alu_b_o     = '0;
        accept      = 1'b0;
        issue       = 1'b0;
        coef_wr     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                busy_o     = 1'b0;
                in_ready_o = 1'b1;
                coef_wr    = coef_we_i;
                if (in_valid_i) begin
                    accept  = 1'b1;
                    k_d     = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                issue   = 1'b1;
                alu_a_o = tap_sample;
                alu_b_o = coef_q[k_q];
                if (k_q == K_LAST) state_d = S_DRAIN;
                else               k_d     = k_q + AW'(1);
            end
            S_DRAIN: begin
                // Only the product being added this cycle may remain in flight.
                if ((tag_q & ~TAG_LAST) == '0) state_d = S_OUT;
            end
            S_OUT: begin
                out_valid_o = 1'b1;
                out_data_o  = acc_q;
                if (out_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, tap counter and tag pipe (one tag per issued multiply).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            tag_q   <= (tag_q << 1) | ALU_LAT'(issue);
        end
    end

    // Accumulator: cleared on accept, adds each tagged product with wrap.
    always_ff @(posedge clk_i) begin
        if (rst_i)                   acc_q <= '0;
        else if (accept)             acc_q <= '0;
        else if (tag_q[ALU_LAT - 1]) acc_q <= acc_q + product_ext;
    end

    // Coefficient bank; writes land only in IDLE, ahead of a same-cycle accept.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NTAPS; i++) coef_q[i] <= '0;
        end else if (coef_wr && ({1'b0, coef_addr_i} < (AW + 1)'(NTAPS))) begin
            coef_q[coef_addr_i] <= coef_data_i;
        end
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Self-checking bench for fir_mac_sequencer with a registered 16x16 ALU peer.
module tb_fir_mac_sequencer;

    localparam int NT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [39:0] out_data;
    logic        coef_we = 1'b0;
    logic [3:0]  coef_addr = '0;
    logic [15:0] coef_data = '0;
    logic        busy;
    logic [1:0]  alu_op;
    logic [15:0] alu_a, alu_b;
    logic [31:0] alu_result;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: coefficient values and sample history (newest first).
    int mcoef [NT];
    int hist [$];

    always #5 clk = ~clk;

    fir_mac_sequencer #(.NTAPS(16), .DATA_W(16), .ALU_LAT(1), .ACC_W(40)) dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_data_i(in_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_data_o(out_data), .coef_we_i(coef_we), .coef_addr_i(coef_addr),
        .coef_data_i(coef_data), .busy_o(busy), .alu_op_o(alu_op),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_result_i(alu_result)
    );

    // Shared ALU: one-cycle registered result.
    always @(posedge clk) begin
        if (rst) alu_result <= '0;
        else case (alu_op)
            2'b00:   alu_result <= int'($signed(alu_a)) * int'($signed(alu_b));
            2'b01:   alu_result <= int'($signed(alu_a)) + int'($signed(alu_b));
            default: alu_result <= int'($signed(alu_a)) - int'($signed(alu_b));
        endcase
    end

    function automatic logic [39:0] ref_y();
        longint s;
        s = 0;
        for (int k = 0; k < NT; k++)
            if (k < hist.size()) s += longint'(mcoef[k]) * longint'(hist[k]);
        return s[39:0];
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < NT; k++) mcoef[k] = 0;
        hist.delete();
    endfunction

    function automatic void model_push(input logic [15:0] x);
        int xi;
        xi = $signed(x);
        hist.push_front(xi);
        if (hist.size() > NT) void'(hist.pop_back());
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic write_coef(input int k, input int v);
        logic [15:0] d;
        d = 16'(v);
        coef_we = 1'b1; coef_addr = 4'(k); coef_data = d;
        @(posedge clk); #1;
        coef_we = 1'b0;
        mcoef[k] = int'($signed(d));
    endtask

    // Feeds one sample from IDLE (optionally with a same-cycle coef write),
    // waits for the result and completes the handshake.
    task automatic send_sample(input logic [15:0] x, input bit we, input logic [3:0] wa,
                               input logic [15:0] wd, output logic [39:0] y,
                               output int lat, output bit rdy_hi, output bit to);
        to = 0; rdy_hi = 0; lat = 0;
        in_valid = 1'b1; in_data = x; coef_we = we; coef_addr = wa; coef_data = wd;
        @(posedge clk); #1;
        in_valid = 1'b0; coef_we = 1'b0;
        if (we) mcoef[wa] = int'($signed(wd));
        model_push(x);
        while (!out_valid && lat < 100) begin
            if (in_ready) rdy_hi = 1;
            @(posedge clk); #1;
            lat++;
        end
        to = !out_valid;
        y = out_data;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (out_data !== 40'd0) begin n_fail++; $display("FAIL reset_out_data: got %0h want 0", out_data); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (alu_op !== 2'b00) begin n_fail++; $display("FAIL reset_alu_op: got %b want 00", alu_op); end
        n_checks++; if (alu_a !== 16'd0 || alu_b !== 16'd0) begin n_fail++; $display("FAIL reset_alu_ab: got %0h/%0h want 0/0", alu_a, alu_b); end
    endtask

    task automatic test_impulse();
        logic [39:0] y; int lat; bit rh, to; logic [39:0] exp_y;
        for (int k = 0; k < NT; k++) write_coef(k, k + 1);
        for (int i = 0; i < 18; i++) begin
            send_sample((i == 0) ? 16'd1 : 16'd0, 0, '0, '0, y, lat, rh, to);
            exp_y = ref_y();
            n_checks++;
            if (to || y !== exp_y) begin
                n_fail++; $display("FAIL impulse[%0d]: got %0d want %0d (timeout=%0b)", i, $signed(y), $signed(exp_y), to);
            end
        end
    endtask

    task automatic test_latency();
        logic [39:0] y; int lat; bit rh, to;
        send_sample(16'd5, 0, '0, '0, y, lat, rh, to);
        n_checks++; if (to || lat != NT + 1) begin n_fail++; $display("FAIL latency: got %0d edges want %0d", lat, NT + 1); end
        n_checks++; if (rh) begin n_fail++; $display("FAIL in_ready_busy: got 1 before handshake want 0"); end
        n_checks++; if (y !== ref_y()) begin n_fail++; $display("FAIL latency_data: got %0d want %0d", $signed(y), $signed(ref_y())); end
    endtask

    task automatic test_max_mag();
        logic [39:0] y; int lat; bit rh, to;
        do_reset();
        for (int k = 0; k < NT; k++) write_coef(k, -32768);
        for (int i = 0; i < NT; i++) begin
            send_sample(16'h8000, 0, '0, '0, y, lat, rh, to);
            n_checks++;
            if (to || y !== ref_y()) begin n_fail++; $display("FAIL maxmag[%0d]: got %0d want %0d", i, $signed(y), $signed(ref_y())); end
        end
        n_checks++; if (y !== 40'd17179869184) begin n_fail++; $display("FAIL maxmag_final: got %0d want 17179869184", $signed(y)); end
    endtask

    task automatic test_stall();
        logic [39:0] y0, y; int cnt, lat; bit rh, to;
        do_reset();
        for (int k = 0; k < NT; k++) write_coef(k, int'($urandom_range(0, 65535)) - 32768);
        for (int i = 0; i < 3; i++) send_sample(16'($urandom), 0, '0, '0, y, lat, rh, to);
        in_valid = 1'b1; in_data = 16'h1234;
        @(posedge clk); #1;
        in_valid = 1'b0;
        model_push(16'h1234);
        cnt = 0;
        while (!out_valid && cnt < 100) begin @(posedge clk); #1; cnt++; end
        n_checks++; if (!out_valid) begin n_fail++; $display("FAIL stall_timeout: got no out_valid want 1"); end
        y0 = out_data;
        n_checks++; if (y0 !== ref_y()) begin n_fail++; $display("FAIL stall_data: got %0d want %0d", $signed(y0), $signed(ref_y())); end
        in_valid = 1'b1; in_data = 16'h7fff;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== y0 || in_ready !== 1'b0) begin
                n_fail++; $display("FAIL stall_hold[%0d]: got v=%b d=%0d r=%b want v=1 d=%0d r=0", c, out_valid, $signed(out_data), in_ready, $signed(y0));
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        n_checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_no_accept: got busy=%b ready=%b want 0/1", busy, in_ready); end
        send_sample(16'h0101, 0, '0, '0, y, lat, rh, to);
        n_checks++; if (to || y !== ref_y()) begin n_fail++; $display("FAIL stall_next: got %0d want %0d", $signed(y), $signed(ref_y())); end
    endtask

    task automatic test_coef_write();
        logic [39:0] y; int cnt, lat; bit rh, to;
        in_valid = 1'b1; in_data = 16'h0300;
        @(posedge clk); #1;
        in_valid = 1'b0;
        model_push(16'h0300);
        repeat (3) @(posedge clk);
        #1;
        coef_we = 1'b1; coef_addr = 4'd0; coef_data = 16'd99;
        @(posedge clk); #1;
        coef_we = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 100) begin @(posedge clk); #1; cnt++; end
        y = out_data;
        n_checks++; if (!out_valid || y !== ref_y()) begin n_fail++; $display("FAIL coef_issue_ignored: got %0d want %0d", $signed(y), $signed(ref_y())); end
        out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
        send_sample(16'h0300, 1, 4'd0, 16'd99, y, lat, rh, to);
        n_checks++; if (to || y !== ref_y()) begin n_fail++; $display("FAIL coef_idle_write: got %0d want %0d", $signed(y), $signed(ref_y())); end
    endtask

    task automatic test_back_to_back();
        logic [39:0] y; int lat; bit rh, to;
        for (int k = 0; k < NT; k++) write_coef(k, int'($urandom_range(0, 65535)) - 32768);
        for (int i = 0; i < 24; i++) begin
            send_sample(16'($urandom), 0, '0, '0, y, lat, rh, to);
            n_checks++;
            if (to || lat != NT + 1 || y !== ref_y()) begin
                n_fail++; $display("FAIL b2b[%0d]: got %0d lat %0d want %0d lat %0d", i, $signed(y), lat, $signed(ref_y()), NT + 1);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [39:0] y; int lat; bit rh, to;
        logic [15:0] xn;
        xn = 16'($urandom);
        in_valid = 1'b1; in_data = xn;
        @(posedge clk); #1;
        in_valid = 1'b0;
        model_push(xn);
        repeat (7) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b1 || alu_a !== 16'(hist[7]) || alu_b !== 16'(mcoef[7])) begin
            n_fail++; $display("FAIL issue_k7: got a=%0h b=%0h want a=%0h b=%0h", alu_a, alu_b, 16'(hist[7]), 16'(mcoef[7]));
        end
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 40'd0 || busy !== 1'b0 ||
            alu_op !== 2'b00 || alu_a !== 16'd0 || alu_b !== 16'd0) begin
            n_fail++; $display("FAIL midreset_outputs: got r=%b v=%b d=%0h busy=%b op=%b a=%0h b=%0h want 1 0 0 0 00 0 0",
                               in_ready, out_valid, out_data, busy, alu_op, alu_a, alu_b);
        end
        rst = 1'b0;
        model_clear();
        send_sample(16'd1, 0, '0, '0, y, lat, rh, to);
        n_checks++; if (to || y !== 40'd0 || y !== ref_y()) begin n_fail++; $display("FAIL midreset_impulse: got %0d want 0", $signed(y)); end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_latency();
        test_max_mag();
        test_stall();
        test_coef_write();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
